// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding controller for the in-order pipeline.
// Tracks destination metadata of in-flight instructions and derives stall, flush and EX forwarding selects.
module hazard_forward_unit #(
    parameter int REG_BITS       = 5,
    parameter int STAGES         = 3,
    parameter int BRANCH_STAGE   = 2,
    parameter int LOAD_FWD_STAGE = 3,
    parameter int CNT_W          = 16,
    localparam int SELW          = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                halted,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs_num,
    input  logic [REG_BITS-1:0] id_rt_num,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [REG_BITS-1:0] id_rd_num,
    input  logic                id_rd_we,
    input  logic                id_is_load,
    input  logic                redirect,
    output logic                stall,
    output logic                flush,
    output logic [SELW-1:0]     ex_fwd_rs_sel,
    output logic [SELW-1:0]     ex_fwd_rt_sel,
    output logic [STAGES-1:0]   stage_valid,
    output logic [CNT_W-1:0]    stall_cycles
);

    // Index k-1 of each vector describes pipeline stage k (stage 1 = EX).
    logic [STAGES-1:0]                sb_valid_r;
    logic [STAGES-1:0]                sb_we_r;
    logic [STAGES-1:0]                sb_load_r;
    logic [STAGES-1:0][REG_BITS-1:0]  sb_rd_r;
    logic [SELW-1:0]                  rs_sel_r;
    logic [SELW-1:0]                  rt_sel_r;
    logic [CNT_W-1:0]                 stall_cycles_r;

    logic [STAGES-1:0]                nxt_valid_s;
    logic [STAGES-1:0]                nxt_we_s;
    logic [STAGES-1:0]                nxt_load_s;
    logic [STAGES-1:0][REG_BITS-1:0]  nxt_rd_s;
    logic [SELW:0]                    rs_res_s;
    logic [SELW:0]                    rt_res_s;
    logic                             hazard_s;
    logic                             stall_s;
    logic                             flush_s;
    logic                             take_id_s;

    // Returns {hazard, select} for one source; the youngest matching writer decides.
    function automatic logic [SELW:0] src_lookup(
        input logic [REG_BITS-1:0]               src,
        input logic                              used,
        input logic [STAGES-1:0]                 v,
        input logic [STAGES-1:0]                 we,
        input logic [STAGES-1:0]                 ld,
        input logic [STAGES-1:0][REG_BITS-1:0]   rd
    );
        logic            found;
        logic            haz;
        logic [SELW-1:0] sel;
        found = 1'b0;
        haz   = 1'b0;
        sel   = {SELW{1'b0}};
        for (int k = 1; k <= STAGES; k++) begin
            if (!found && used && (src != {REG_BITS{1'b0}}) && v[k-1] && we[k-1] && (rd[k-1] == src)) begin
                found = 1'b1;
                if (k == STAGES) begin
                    sel = {SELW{1'b0}};
                end else if (ld[k-1] && ((k + 1) < LOAD_FWD_STAGE)) begin
                    haz = 1'b1;
                end else begin
                    sel = SELW'(k + 1);
                end
            end
        end
        return {haz, sel};
    endfunction

    // Hazard resolution and the combinational stall/flush decision.
    always_comb begin
        rs_res_s = src_lookup(id_rs_num, id_rs_used, sb_valid_r, sb_we_r, sb_load_r, sb_rd_r);
        rt_res_s = src_lookup(id_rt_num, id_rt_used, sb_valid_r, sb_we_r, sb_load_r, sb_rd_r);
        hazard_s = rs_res_s[SELW] | rt_res_s[SELW];
        flush_s  = redirect & ~halted;
        if (halted) begin
            stall_s = 1'b1;
        end else begin
            stall_s = id_valid & hazard_s & ~redirect;
        end
        take_id_s = id_valid & ~stall_s & ~flush_s;
    end

    // Next scoreboard contents: shift by one stage, bubbles for flushed or stalled slots.
    always_comb begin
        nxt_valid_s = {STAGES{1'b0}};
        nxt_we_s    = {STAGES{1'b0}};
        nxt_load_s  = {STAGES{1'b0}};
        nxt_rd_s    = {STAGES{{REG_BITS{1'b0}}}};
        if (take_id_s) begin
            nxt_valid_s[0] = 1'b1;
            nxt_we_s[0]    = id_rd_we;
            nxt_load_s[0]  = id_is_load;
            nxt_rd_s[0]    = id_rd_num;
        end else begin
            nxt_valid_s[0] = 1'b0;
        end
        for (int k = 1; k < STAGES; k++) begin
            // The redirecting instruction itself moves past BRANCH_STAGE and survives.
            if (flush_s && (k < BRANCH_STAGE)) begin
                nxt_valid_s[k] = 1'b0;
            end else begin
                nxt_valid_s[k] = sb_valid_r[k-1];
                nxt_we_s[k]    = sb_we_r[k-1];
                nxt_load_s[k]  = sb_load_r[k-1];
                nxt_rd_s[k]    = sb_rd_r[k-1];
            end
        end
    end

    // Scoreboard, forwarding selects and stall counter; all frozen while halted.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sb_valid_r     <= {STAGES{1'b0}};
            sb_we_r        <= {STAGES{1'b0}};
            sb_load_r      <= {STAGES{1'b0}};
            sb_rd_r        <= {STAGES{{REG_BITS{1'b0}}}};
            rs_sel_r       <= {SELW{1'b0}};
            rt_sel_r       <= {SELW{1'b0}};
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!halted) begin
            sb_valid_r <= nxt_valid_s;
            sb_we_r    <= nxt_we_s;
            sb_load_r  <= nxt_load_s;
            sb_rd_r    <= nxt_rd_s;
            rs_sel_r   <= take_id_s ? rs_res_s[SELW-1:0] : {SELW{1'b0}};
            rt_sel_r   <= take_id_s ? rt_res_s[SELW-1:0] : {SELW{1'b0}};
            if (stall_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end
        end
    end

    assign stall         = stall_s;
    assign flush         = flush_s;
    assign ex_fwd_rs_sel = rs_sel_r;
    assign ex_fwd_rt_sel = rt_sel_r;
    assign stage_valid   = sb_valid_r;
    assign stall_cycles  = stall_cycles_r;

endmodule
